addsub_sequencer: RTL and testbench
===================================

ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

Interface
REQ-001 Parameter SETTLE, default 1, range 1-15: cycles the adder operands are held before the result is captured.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  command present.
REQ-005 in_ready  output  1  block accepts a command this cycle.
REQ-006 in_a  input  4  operand A.
REQ-007 in_b  input  4  operand B.
REQ-008 in_sub  input  1  operation select: 1 = A-B, 0 = A+B.
REQ-009 in_cin  input  1  carry-in, used for add only.
REQ-010 in_acc  input  1  1 = use the accumulator in place of in_a.
REQ-011 add_a, add_b  output  4 each  operands to the downstream adder.
REQ-012 add_s, add_cin  output  1 each  subtract select and carry-in to the adder.
REQ-013 add_sum  input  4  adder result (magnitude).
REQ-014 add_cout  input  1  adder carry-out.
REQ-015 add_neg  input  1  adder negative flag.
REQ-016 out_valid  output  1  result available.
REQ-017 out_ready  input  1  consumer accepts the result.
REQ-018 out_sum  output  4  captured sum.
REQ-019 out_cout  output  1  captured carry-out.
REQ-020 out_neg  output  1  captured negative flag.

Function
REQ-021 The block SHALL implement an FSM with states IDLE, DRIVE, CAPTURE and HOLD.
REQ-022 in_ready SHALL be 1 only in IDLE; a command is accepted when in_valid and in_ready are both 1.
REQ-023 On accept: register A (from in_acc ? acc : in_a), B, in_sub and in_cin; then go to DRIVE and load the settle counter with SETTLE-1.
REQ-024 In DRIVE and CAPTURE, add_a/add_b/add_s SHALL present the registered operands, held stable; add_cin SHALL be the registered cin in add mode and 0 in subtract mode.
REQ-025 In IDLE and HOLD, the add_* outputs SHALL be 0.
REQ-026 DRIVE SHALL decrement the counter each cycle and go to CAPTURE when the counter is 0, giving exactly SETTLE cycles in DRIVE.
REQ-027 CAPTURE SHALL register add_sum, add_cout and add_neg into out_*, load acc with add_sum, and go to HOLD (one cycle).
REQ-028 HOLD SHALL assert out_valid and keep out_* stable until out_ready = 1, then return to IDLE.
REQ-029 Latency SHALL be SETTLE+2 cycles from the accept edge to the first out_valid cycle; the return to IDLE adds one mandatory bubble before the next accept.
REQ-030 out_* SHALL keep their last captured values after HOLD; only out_valid deasserts.
REQ-031 acc SHALL hold the 4-bit magnitude only: neg and cout are not stored, and overflow wraps modulo 16.
REQ-032 in_valid while not in IDLE SHALL be ignored, with no state change.
REQ-033 in_acc = 1 on the first command after reset SHALL use acc = 0.

Reset
REQ-034 rst_n = 0 SHALL immediately force: state IDLE, counter 0, acc 0, all registered operands 0, out_sum 0, out_cout 0, out_neg 0, out_valid 0, add_* outputs 0.
REQ-035 A reset asserted in any state SHALL abandon the operation, with no partial capture and acc cleared; after release, in_ready = 1 on the first edge.

Verification
REQ-036 Add, SETTLE=1: A=3, B=5, sub=0, cin=0 -> out_valid 3 cycles after accept; out_sum=8, out_cout=0, out_neg=0.
REQ-037 Subtract: A=2, B=7, sub=1, cin=1 -> add_cin=0 while driving; out_sum=5, out_neg=1.
REQ-038 Carry: A=15, B=1, sub=0, cin=1 -> out_sum=1, out_cout=1; acc=1.
REQ-039 Accumulate: A=9, B=0 add, then in_acc=1, in_a=0, B=4 add -> second result out_sum=13.
REQ-040 Backpressure: out_ready held 0 for 5 cycles -> out_valid and out_* remain stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-041 Reset during DRIVE, SETTLE=4 -> all outputs 0 immediately, no out_valid pulse, acc=0 after release.

Source files
------------

// File: rtl/addsub_sequencer.sv
// addsub_sequencer: sequences one add/subtract command through an external
// combinational adder. It holds the operands for SETTLE cycles, captures the
// adder result, and presents it until the consumer accepts it. The captured
// magnitude also feeds a 4-bit accumulator that later commands may use as A.
module addsub_sequencer #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   input  logic       in_sub,
   input  logic       in_cin,
   input  logic       in_acc,
   output logic [3:0] add_a,
   output logic [3:0] add_b,
   output logic       add_s,
   output logic       add_cin,
   input  logic [3:0] add_sum,
   input  logic       add_cout,
   input  logic       add_neg,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_sum,
   output logic       out_cout,
   output logic       out_neg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   // Counter reload gives exactly SETTLE cycles in DRIVE (exit when it hits 0).
   localparam logic [3:0] LP_CNT_INIT = 4'(SETTLE - 1);

   state_t     r_state;
   logic [3:0] r_cnt;
   logic [3:0] r_acc;
   logic [3:0] r_a;
   logic [3:0] r_b;
   logic       r_sub;
   logic       r_cin;
   logic       r_out_valid;
   logic [3:0] r_out_sum;
   logic       r_out_cout;
   logic       r_out_neg;

   logic       w_accept;
   logic       w_drive_ops;
   logic [3:0] w_op_a;

   assign w_accept    = in_valid && (r_state == IDLE);
   assign w_op_a      = in_acc ? r_acc : in_a;
   assign w_drive_ops = (r_state == DRIVE) || (r_state == CAPTURE);

   // Operands reach the adder only while an operation is in flight; carry-in
   // is forced low in subtract mode so the adder sees a clean A-B.
   assign in_ready  = (r_state == IDLE);
   assign add_a     = w_drive_ops ? r_a : 4'd0;
   assign add_b     = w_drive_ops ? r_b : 4'd0;
   assign add_s     = w_drive_ops ? r_sub : 1'b0;
   assign add_cin   = (w_drive_ops && !r_sub) ? r_cin : 1'b0;
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign out_cout  = r_out_cout;
   assign out_neg   = r_out_neg;

   // Main sequencer: accept, settle, capture, then hold until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_acc       <= 4'd0;
         r_a         <= 4'd0;
         r_b         <= 4'd0;
         r_sub       <= 1'b0;
         r_cin       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= 4'd0;
         r_out_cout  <= 1'b0;
         r_out_neg   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a     <= w_op_a;
                  r_b     <= in_b;
                  r_sub   <= in_sub;
                  r_cin   <= in_cin;
                  r_cnt   <= LP_CNT_INIT;
                  r_state <= DRIVE;
               end
            end
            DRIVE: begin
               if (r_cnt == 4'd0) begin
                  r_state <= CAPTURE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            CAPTURE: begin
               r_out_sum   <= add_sum;
               r_out_cout  <= add_cout;
               r_out_neg   <= add_neg;
               r_acc       <= add_sum;
               r_out_valid <= 1'b1;
               r_state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Bench for addsub_sequencer: two instances (SETTLE=1 and SETTLE=4) share the
// command bus; each has its own behavioural adder. Expected results are queued
// when a command is issued and popped when the selected instance shows out_valid.
module tb_addsub_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       v1 = 1'b0;
   logic       v4 = 1'b0;
   logic [3:0] in_a = 4'd0;
   logic [3:0] in_b = 4'd0;
   logic       in_sub = 1'b0;
   logic       in_cin = 1'b0;
   logic       in_acc = 1'b0;
   logic       out_ready = 1'b0;
   bit         sel = 1'b0;

   logic       rdy1, rdy4;
   logic [3:0] aa1, ab1, aa4, ab4;
   logic       as1, ac1, as4, ac4;
   logic [5:0] res1, res4;
   logic       ov1, ov4;
   logic [3:0] os1, os4;
   logic       oc1, on1, oc4, on4;

   int n_chk = 0;
   int n_pass = 0;
   logic [3:0] m_acc [2];

   typedef struct packed {
      logic [3:0] sum;
      logic       cout;
      logic       neg;
   } res_t;
   res_t sb_q [$];

   always #5 clk = ~clk;

   // Behavioural downstream adder: returns {neg, cout, sum[3:0]}.
   function automatic logic [5:0] adder(input logic [3:0] a, input logic [3:0] b,
                                        input logic s, input logic cin);
      logic [4:0] t;
      if (!s) begin
         t = {1'b0, a} + {1'b0, b} + {4'd0, cin};
         return {1'b0, t[4], t[3:0]};
      end else if (a >= b) begin
         return {1'b0, 1'b1, a - b};
      end else begin
         return {1'b1, 1'b0, b - a};
      end
   endfunction

   assign res1 = adder(aa1, ab1, as1, ac1);
   assign res4 = adder(aa4, ab4, as4, ac4);

   addsub_sequencer #(.SETTLE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin), .in_acc(in_acc),
      .add_a(aa1), .add_b(ab1), .add_s(as1), .add_cin(ac1),
      .add_sum(res1[3:0]), .add_cout(res1[4]), .add_neg(res1[5]),
      .out_valid(ov1), .out_ready(out_ready),
      .out_sum(os1), .out_cout(oc1), .out_neg(on1)
   );

   addsub_sequencer #(.SETTLE(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin), .in_acc(in_acc),
      .add_a(aa4), .add_b(ab4), .add_s(as4), .add_cin(ac4),
      .add_sum(res4[3:0]), .add_cout(res4[4]), .add_neg(res4[5]),
      .out_valid(ov4), .out_ready(out_ready),
      .out_sum(os4), .out_cout(oc4), .out_neg(on4)
   );

   logic       m_rdy, m_ov, m_as, m_ac, m_oc, m_on;
   logic [3:0] m_aa, m_ab, m_os;
   assign m_rdy = sel ? rdy4 : rdy1;
   assign m_ov  = sel ? ov4 : ov1;
   assign m_aa  = sel ? aa4 : aa1;
   assign m_ab  = sel ? ab4 : ab1;
   assign m_as  = sel ? as4 : as1;
   assign m_ac  = sel ? ac4 : ac1;
   assign m_os  = sel ? os4 : os1;
   assign m_oc  = sel ? oc4 : oc1;
   assign m_on  = sel ? on4 : on1;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command on the selected instance, check the operand bus while
   // it is in flight, the latency, the popped result, and the return to IDLE.
   task automatic do_cmd(input bit s, input logic [3:0] a, input logic [3:0] b,
                         input logic sub, input logic cin, input logic acc,
                         input int bp);
      logic [3:0] opa;
      logic [5:0] r;
      res_t       exp_r;
      res_t       got;
      int         lat;
      int         settle;
      sel    = s;
      settle = s ? 4 : 1;
      opa    = acc ? m_acc[s] : a;
      r      = adder(opa, b, sub, sub ? 1'b0 : cin);
      exp_r  = '{sum: r[3:0], cout: r[4], neg: r[5]};
      sb_q.push_back(exp_r);
      m_acc[s] = r[3:0];
      in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_acc = acc;
      if (s) v4 = 1'b1; else v1 = 1'b1;
      chk("accept_ready", int'(m_rdy), 1);
      tick();
      v1 = 1'b0; v4 = 1'b0;
      in_a = 4'hF; in_b = 4'hF; in_acc = 1'b0;
      lat = 1;
      while (!m_ov && lat < 40) begin
         chk("drive_add_a", int'(m_aa), int'(opa));
         chk("drive_add_b", int'(m_ab), int'(b));
         chk("drive_add_s", int'(m_as), int'(sub));
         chk("drive_add_cin", int'(m_ac), int'(sub ? 1'b0 : cin));
         chk("busy_in_ready", int'(m_rdy), 0);
         tick();
         lat++;
      end
      chk("latency", lat, settle + 2);
      got = sb_q.pop_front();
      chk("out_sum", int'(m_os), int'(got.sum));
      chk("out_cout", int'(m_oc), int'(got.cout));
      chk("out_neg", int'(m_on), int'(got.neg));
      chk("hold_add_a", int'(m_aa), 0);
      for (int i = 0; i < bp; i++) begin
         if (s) v4 = 1'b1; else v1 = 1'b1;
         in_a = 4'd7; in_b = 4'd7;
         tick();
         chk("bp_out_valid", int'(m_ov), 1);
         chk("bp_out_sum", int'(m_os), int'(got.sum));
         chk("bp_out_neg", int'(m_on), int'(got.neg));
         chk("bp_in_ready", int'(m_rdy), 0);
      end
      v1 = 1'b0; v4 = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("idle_in_ready", int'(m_rdy), 1);
      chk("idle_out_valid", int'(m_ov), 0);
      chk("idle_out_sum_kept", int'(m_os), int'(got.sum));
      chk("idle_add_b", int'(m_ab), 0);
   endtask

   initial begin
      bit seen_ov;
      m_acc[0] = 4'd0;
      m_acc[1] = 4'd0;
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", int'(rdy1), 1);
      chk("rst_out_valid", int'(ov1), 0);
      chk("rst_out_sum", int'(os1), 0);
      chk("rst_add_a", int'(aa1), 0);
      chk("rst4_out_valid", int'(ov4), 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", int'(rdy1), 1);

      // SETTLE=1 instance: add, subtract, carry, accumulate, backpressure.
      do_cmd(1'b0, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 0);
      chk("add_3_5", int'(os1), 8);
      do_cmd(1'b0, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0, 0);
      chk("sub_2_7_neg", int'(on1), 1);
      do_cmd(1'b0, 4'd15, 4'd1, 1'b0, 1'b1, 1'b0, 0);
      chk("carry_cout", int'(oc1), 1);
      do_cmd(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 0);
      chk("acc_after_carry", int'(os1), 1);
      do_cmd(1'b0, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0, 0);
      do_cmd(1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b1, 0);
      chk("accumulate_13", int'(os1), 13);
      do_cmd(1'b0, 4'd12, 4'd6, 1'b0, 1'b0, 1'b1, 5);
      chk("acc_wrap", int'(os1), 3);
      do_cmd(1'b0, 4'd8, 4'd8, 1'b1, 1'b0, 1'b0, 2);

      // SETTLE=4 instance: normal command, then reset while driving.
      do_cmd(1'b1, 4'd6, 4'd3, 1'b0, 1'b0, 1'b0, 0);
      sel = 1'b1;
      in_a = 4'd0; in_b = 4'd2; in_sub = 1'b0; in_cin = 1'b1; in_acc = 1'b1;
      v4 = 1'b1;
      tick();
      v4 = 1'b0; in_acc = 1'b0;
      tick();
      chk("drv4_add_a_acc", int'(aa4), 9);
      rst_n = 1'b0;
      #1;
      chk("rstdrv_add_a", int'(aa4), 0);
      chk("rstdrv_add_b", int'(ab4), 0);
      chk("rstdrv_add_cin", int'(ac4), 0);
      chk("rstdrv_out_sum", int'(os4), 0);
      chk("rstdrv_out_valid", int'(ov4), 0);
      m_acc[0] = 4'd0;
      m_acc[1] = 4'd0;
      sb_q.delete();
      tick();
      rst_n = 1'b1;
      chk("rstdrv_ready", int'(rdy4), 1);
      seen_ov = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ov4) seen_ov = 1'b1;
      end
      chk("rstdrv_no_valid", int'(seen_ov), 0);
      do_cmd(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 0);
      chk("rstdrv_acc_zero", int'(os4), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
